// File: rtl/seq_multiplier.sv
// seq_multiplier: multi-cycle shift-and-add multiplier that retires K
// multiplier bits per clock. It handles unsigned or two's-complement operands,
// chosen per operation, and uses valid/ready handshakes on both the request
// side and the result side.
//
// Ports:
//   i_clock        rising-edge clock
//   i_reset        synchronous, active-high reset
//   i_valid        operands valid (request)
//   o_ready        block can accept operands (high only in IDLE)
//   i_signed       1 = two's-complement operands, 0 = unsigned (sampled at accept)
//   i_multiplicand operand A, N bits (sampled at accept)
//   i_multiplier   operand B, N bits (sampled at accept)
//   o_valid        o_product holds a completed result
//   i_ready        consumer accepts the result
//   o_product      registered 2N-bit product, held until the next result
//   o_busy         high while the multiply is running (RUN and FIX)
module seq_multiplier #(
    parameter int N = 8,
    parameter int K = 1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic           i_signed,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [2*N-1:0] o_product,
    output logic           o_busy
);

    // Reject illegal parameter combinations at elaboration time.
    generate
        if (!((K == 1) || (K == 2) || (K == 4)) || (N < 2) || ((N % K) != 0)) begin : g_bad_params
            $error("seq_multiplier: illegal N/K combination");
        end
    endgenerate

    localparam int STEPS = N / K;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STEPS - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [N-1:0]   ONE_N    = N'(1);
    localparam logic [2*N-1:0] ONE_2N   = (2*N)'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [CW-1:0]   cnt_r;
    logic [2*N-1:0]  mcand_r;
    logic [N-1:0]    mplier_r;
    logic [2*N-1:0]  acc_r;
    logic            neg_r;
    logic [2*N-1:0]  product_r;
    logic            valid_r;
    logic            ready_r;
    logic            busy_r;
    logic            accept_s;
    logic [2*N-1:0]  partial_s;

    // Magnitude of an operand; -2^(N-1) maps to 2^(N-1), which still fits in N bits.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
        logic [N-1:0] r;
        if (sgn && v[N-1]) begin
            r = ~v + ONE_N;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Shifted multiplicand times the K low multiplier bits, as a sum of shifted copies.
    function automatic logic [2*N-1:0] partial_product(input logic [2*N-1:0] m, input logic [K-1:0] bits);
        logic [2*N-1:0] sum;
        sum = '0;
        for (int j = 0; j < K; j++) begin
            if (bits[j]) begin
                sum = sum + (m << j);
            end else begin
                sum = sum;
            end
        end
        return sum;
    endfunction

    assign accept_s  = (state_r == ST_IDLE) && i_valid;
    assign partial_s = partial_product(mcand_r, mplier_r[K-1:0]);

    // Next-state logic for the IDLE -> RUN -> FIX -> DONE sequence.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_LAST) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX: begin
                state_next_s = ST_DONE;
            end
            ST_DONE: begin
                // o_valid is always high in DONE, so i_ready alone completes the handshake.
                if (i_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered handshake/status flags derived from the next state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready_r <= (state_next_s == ST_IDLE);
            busy_r  <= (state_next_s == ST_RUN) || (state_next_s == ST_FIX);
        end
    end

    // Datapath: operand capture, shift-and-add iterations, sign fix-up and result hold.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_r     <= '0;
            mcand_r   <= '0;
            mplier_r  <= '0;
            acc_r     <= '0;
            neg_r     <= 1'b0;
            product_r <= '0;
            valid_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= '0;
                        mcand_r  <= {{N{1'b0}}, magnitude(i_multiplicand, i_signed)};
                        mplier_r <= magnitude(i_multiplier, i_signed);
                        neg_r    <= i_signed & (i_multiplicand[N-1] ^ i_multiplier[N-1]);
                        acc_r    <= '0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                ST_RUN: begin
                    // Carry out of the accumulator cannot occur: |A|*|B| < 2^(2N).
                    acc_r    <= acc_r + partial_s;
                    mcand_r  <= mcand_r << K;
                    mplier_r <= mplier_r >> K;
                    cnt_r    <= cnt_r + CNT_ONE;
                end
                ST_FIX: begin
                    // Negating a zero magnitude wraps back to zero.
                    if (neg_r) begin
                        product_r <= ~acc_r + ONE_2N;
                    end else begin
                        product_r <= acc_r;
                    end
                    valid_r <= 1'b1;
                end
                ST_DONE: begin
                    if (i_ready) begin
                        valid_r <= 1'b0;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready   = ready_r;
    assign o_valid   = valid_r;
    assign o_busy    = busy_r;
    assign o_product = product_r;

endmodule
